// File: rtl/comp_pkg.sv
// Shared types and sizing constants for the comp boot path.
// Used by the program loader and its byte assembler.
package comp_pkg;

   localparam int WORD_BYTES = 4;
   localparam int MEM_WORDS  = 256;

   typedef enum logic [2:0] {
      IDLE,
      HDR1,
      LOAD,
      CRST,
      RUN,
      DONE,
      ERR
   } loader_state_e;

endpackage

// File: rtl/prog_loader_byte_to_word.sv
// Little-endian byte-to-word assembler with a wrapping lane counter.
// word/word_valid reflect the word completed by the byte accepted now.
module byte_to_word
   import comp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  octet,
   input  logic        accept,
   input  logic        clear,
   output logic [31:0] word,
   output logic        word_valid
);

   localparam int LW = $clog2(WORD_BYTES);

   logic [LW-1:0] lane;
   logic [31:0]   shreg;

   // Bytes shift in from the top, so the first byte ends up in [7:0].
   assign word       = {octet, shreg[31:8]};
   assign word_valid = accept && (lane == LW'(WORD_BYTES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane  <= '0;
         shreg <= '0;
      end else if (clear) begin
         lane  <= '0;
      end else if (accept) begin
         lane  <= lane + 1'b1;
         shreg <= word;
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Boot loader for comp: length-prefixed byte image -> OOB word writes,
// then core reset pulse and a timed run until halt or timeout.
module prog_loader
   import comp_pkg::*;
#(
   parameter int unsigned MAX_WORDS      = MEM_WORDS,
   parameter int unsigned RST_CYCLES     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] oob_wr_addr,
   output logic [31:0] oob_wr_data,
   output logic        oob_wen,
   output logic        core_rst,
   input  logic        halt,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] run_cycles
);

   loader_state_e state, state_nxt;

   logic [7:0]  n_lo;
   logic [15:0] n_full;
   logic [15:0] nwords;
   logic [15:0] idx;
   logic [31:0] rst_cnt;
   logic [31:0] word;
   logic        word_valid;
   logic        hdr_bad;
   logic        hdr_ok;
   logic        accept;
   logic        last_word;
   logic        timeout_hit;

   assign n_full      = {in_data, n_lo};
   assign hdr_bad     = (n_full == 16'd0) || (32'(n_full) > MAX_WORDS);
   assign hdr_ok      = (state == HDR1) && in_valid && !hdr_bad;
   assign accept      = (state == LOAD) && in_valid;
   assign last_word   = word_valid && (idx == nwords - 16'd1);
   assign timeout_hit = run_cycles >= (TIMEOUT_CYCLES - 1);

   byte_to_word u_b2w (
      .clk        (clk),
      .rst_n      (rst_n),
      .octet      (in_data),
      .accept     (accept),
      .clear      (hdr_ok),
      .word       (word),
      .word_valid (word_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (in_valid) state_nxt = HDR1;
         HDR1:    if (in_valid) state_nxt = hdr_bad ? ERR : LOAD;
         LOAD:    if (last_word) state_nxt = CRST;
         CRST:    if (rst_cnt == RST_CYCLES - 1) state_nxt = RUN;
         RUN:     if (halt || timeout_hit) state_nxt = DONE;
         DONE:    if (in_valid) state_nxt = HDR1;
         ERR:     state_nxt = ERR;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      core_rst = 1'b1;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state)
         IDLE: in_ready = 1'b1;
         HDR1, LOAD: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         CRST: busy = 1'b1;
         RUN: begin
            busy     = 1'b1;
            core_rst = 1'b0;
         end
         DONE: begin
            done     = 1'b1;
            core_rst = 1'b0;
            in_ready = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_lo        <= '0;
         nwords      <= '0;
         idx         <= '0;
         rst_cnt     <= '0;
         oob_wen     <= 1'b0;
         oob_wr_addr <= '0;
         oob_wr_data <= '0;
         err         <= 1'b0;
         run_cycles  <= '0;
      end else begin
         oob_wen <= 1'b0;
         unique case (state)
            IDLE, DONE: if (in_valid) n_lo <= in_data;
            HDR1: begin
               if (in_valid && hdr_bad) err <= 1'b1;
               if (hdr_ok) begin
                  nwords <= n_full;
                  idx    <= '0;
                  err    <= 1'b0;
               end
            end
            LOAD: if (word_valid) begin
               oob_wen     <= 1'b1;
               oob_wr_addr <= {16'd0, idx};
               oob_wr_data <= word;
               idx         <= idx + 16'd1;
               if (last_word) begin
                  rst_cnt    <= '0;
                  run_cycles <= '0;
               end
            end
            CRST: rst_cnt <= rst_cnt + 32'd1;
            // halt freezes the count and takes priority over timeout
            RUN: if (!halt) begin
               run_cycles <= run_cycles + 32'd1;
               if (timeout_hit) err <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: image table plus reset/error sequences.
module tb_prog_loader;

   localparam int unsigned TMO = 50;
   localparam int unsigned RSTC = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] oob_wr_addr;
   logic [31:0] oob_wr_data;
   logic        oob_wen;
   logic        core_rst;
   logic        halt = 1'b0;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] run_cycles;

   int tests = 0;
   int failed = 0;

   logic [31:0] wr_addr [0:15];
   logic [31:0] wr_data [0:15];
   int          wr_n = 0;

   typedef struct {
      logic [15:0] n;
      logic [63:0] img;
      int          halt_dly;
      bit          gap;
      logic        exp_err;
      logic [31:0] exp_run;
   } vec_t;

   vec_t vecs [5];

   prog_loader #(
      .MAX_WORDS      (256),
      .RST_CYCLES     (RSTC),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .oob_wr_addr (oob_wr_addr),
      .oob_wr_data (oob_wr_data),
      .oob_wen     (oob_wen),
      .core_rst    (core_rst),
      .halt        (halt),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .run_cycles  (run_cycles)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (oob_wen) begin
         if (wr_n < 16) begin
            wr_addr[wr_n] = oob_wr_addr;
            wr_data[wr_n] = oob_wr_data;
         end
         wr_n = wr_n + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap);
      in_data  = b;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      if (gap) begin
         in_data = 8'hA5;
         @(negedge clk);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, " oob_wen"}, 32'(oob_wen), 32'd0);
      chk({tag, " oob_wr_addr"}, oob_wr_addr, 32'd0);
      chk({tag, " oob_wr_data"}, oob_wr_data, 32'd0);
      chk({tag, " core_rst"}, 32'(core_rst), 32'd1);
      chk({tag, " busy"}, 32'(busy), 32'd0);
      chk({tag, " done"}, 32'(done), 32'd0);
      chk({tag, " err"}, 32'(err), 32'd0);
      chk({tag, " run_cycles"}, run_cycles, 32'd0);
   endtask

   task automatic run_image(input string tag, input vec_t v);
      int nb;
      int rlen;
      int lim;
      nb   = 4 * int'(v.n);
      wr_n = 0;
      send_byte(v.n[7:0], 1'b0);
      chk({tag, " hdr0 done"}, 32'(done), 32'd0);
      chk({tag, " hdr0 core_rst"}, 32'(core_rst), 32'd1);
      chk({tag, " hdr0 busy"}, 32'(busy), 32'd1);
      send_byte(v.n[15:8], v.gap);
      for (int k = 0; k < nb; k++)
         send_byte(v.img[8*k +: 8], v.gap && (k != nb - 1));
      chk({tag, " last write wen"}, 32'(oob_wen), 32'd1);
      chk({tag, " in_ready low"}, 32'(in_ready), 32'd0);
      rlen = 0;
      while (core_rst === 1'b1 && rlen < 100) begin
         rlen++;
         @(negedge clk);
      end
      chk({tag, " core_rst len"}, 32'(rlen), 32'(RSTC));
      if (v.halt_dly >= 0) begin
         repeat (v.halt_dly) @(negedge clk);
         halt = 1'b1;
      end
      lim = 0;
      while (done !== 1'b1 && lim < 200) begin
         @(negedge clk);
         lim++;
      end
      halt = 1'b0;
      chk({tag, " done"}, 32'(done), 32'd1);
      chk({tag, " err"}, 32'(err), 32'(v.exp_err));
      chk({tag, " run_cycles"}, run_cycles, v.exp_run);
      chk({tag, " core_rst after"}, 32'(core_rst), 32'd0);
      chk({tag, " in_ready after"}, 32'(in_ready), 32'd1);
      chk({tag, " write count"}, 32'(wr_n), 32'(v.n));
      for (int k = 0; k < int'(v.n) && k < wr_n && k < 16; k++) begin
         chk($sformatf("%s addr%0d", tag, k), wr_addr[k], 32'(k));
         chk($sformatf("%s data%0d", tag, k), wr_data[k],
             v.img[32*k +: 32]);
      end
   endtask

   logic [15:0] bad_hdr [2];

   initial begin
      vecs[0] = '{16'd2, 64'h00100093_00500013, 7, 1'b0, 1'b0, 32'd7};
      vecs[1] = '{16'd1, 64'h00000000_DEADBEEF, 3, 1'b1, 1'b0, 32'd3};
      vecs[2] = '{16'd1, 64'h00000000_12345678, -1, 1'b0, 1'b1, 32'd50};
      vecs[3] = '{16'd1, 64'h00000000_CAFEF00D, 0, 1'b0, 1'b0, 32'd0};
      vecs[4] = '{16'd2, 64'h89ABCDEF_01234567, 49, 1'b1, 1'b0, 32'd49};
      bad_hdr[0] = 16'h0000;
      bad_hdr[1] = 16'h0101;

      #1;
      check_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++)
         run_image($sformatf("vec%0d", i), vecs[i]);

      wr_n = 0;
      send_byte(8'h03, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      send_byte(8'h44, 1'b0);
      send_byte(8'h55, 1'b0);
      chk("midload writes", 32'(wr_n), 32'd1);
      chk("midload data0", wr_data[0], 32'h44332211);
      rst_n = 1'b0;
      #1;
      check_reset_vals("midload rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_image("fresh", '{16'd1, 64'h0BADF00D, 2, 1'b0, 1'b0, 32'd2});

      for (int i = 0; i < 2; i++) begin
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);
         wr_n = 0;
         send_byte(bad_hdr[i][7:0], 1'b0);
         send_byte(bad_hdr[i][15:8], 1'b0);
         chk($sformatf("badhdr%0d err", i), 32'(err), 32'd1);
         chk($sformatf("badhdr%0d in_ready", i), 32'(in_ready), 32'd0);
         chk($sformatf("badhdr%0d core_rst", i), 32'(core_rst), 32'd1);
         chk($sformatf("badhdr%0d busy", i), 32'(busy), 32'd0);
         in_data  = 8'h13;
         in_valid = 1'b1;
         halt     = 1'b1;
         repeat (8) @(negedge clk);
         chk($sformatf("badhdr%0d sticky err", i), 32'(err), 32'd1);
         chk($sformatf("badhdr%0d no write", i), 32'(wr_n), 32'd0);
         chk($sformatf("badhdr%0d done", i), 32'(done), 32'd0);
         chk($sformatf("badhdr%0d hold rst", i), 32'(core_rst), 32'd1);
         in_valid = 1'b0;
         halt     = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
